// File: rtl/bike_io_pkg.sv
// Shared types and default constants for the bike input front end.
package bike_io_pkg;

  typedef enum logic [1:0] {
    STABLE_HI = 2'd0,
    PEND_LO   = 2'd1,
    STABLE_LO = 2'd2,
    PEND_HI   = 2'd3
  } db_state_t;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned CH_FORK  = 0;
  localparam int unsigned CH_CRANK = 1;
  localparam int unsigned CH_MODE  = 2;
  localparam int unsigned CH_TRIP  = 3;

  localparam int unsigned SENSOR_DB_DEF   = 8;
  localparam int unsigned BUTTON_DB_DEF   = 128;
  localparam int unsigned HOLD_CYCLES_DEF = 25600;
  localparam int unsigned CNT_W_DEF       = 15;

endpackage

// File: rtl/debounce_chan.sv
// One input channel: 2-flop synchroniser, 4-state debounce FSM, falling-edge pulse.
module debounce_chan
  import bike_io_pkg::*;
#(
  parameter int unsigned DB    = SENSOR_DB_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic clean_o,
  output logic pulse_o
);

  if (DB == 0) begin : g_bad_db
    $error("debounce_chan: DB must be at least 1");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB - 1);

  logic [1:0]       sync_q;
  logic             s;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;
  logic             pulse_q, pulse_d;

  assign s = sync_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      state_q <= STABLE_HI;
      cnt_q   <= '0;
      clean_q <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      pulse_q <= pulse_d;
    end
  end

  // With DB==1 the pending states are skipped: one differing sample confirms.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    pulse_d = 1'b0;
    case (state_q)
      STABLE_HI: if (!s) begin
        if (DB == 1) begin
          state_d = STABLE_LO;
          clean_d = 1'b0;
          pulse_d = 1'b1;
        end else begin
          state_d = PEND_LO;
          cnt_d   = CNT_W'(1);
        end
      end
      PEND_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          clean_d = 1'b0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_LO: if (s) begin
        if (DB == 1) begin
          state_d = STABLE_HI;
          clean_d = 1'b1;
        end else begin
          state_d = PEND_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      PEND_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          clean_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_HI;
        cnt_d   = '0;
        clean_d = 1'b1;
      end
    endcase
  end

  assign clean_o = clean_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions the four raw active-low bike inputs into clean levels, press pulses and ModeHold.
module input_conditioner
  import bike_io_pkg::*;
#(
  parameter int unsigned SENSOR_DB   = SENSOR_DB_DEF,
  parameter int unsigned BUTTON_DB   = BUTTON_DB_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic nFork_raw,
  input  logic nCrank_raw,
  input  logic nMode_raw,
  input  logic nTrip_raw,
  output logic nFork,
  output logic nCrank,
  output logic nMode,
  output logic nTrip,
  output logic ForkPulse,
  output logic CrankPulse,
  output logic ModePress,
  output logic TripPress,
  output logic ModeHold
);

  if (HOLD_CYCLES >= (1 << CNT_W) || BUTTON_DB >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("input_conditioner: CNT_W too narrow for BUTTON_DB/HOLD_CYCLES");
  end

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

  logic [NUM_CH-1:0] raw, clean, pulse;

  assign raw[CH_FORK]  = nFork_raw;
  assign raw[CH_CRANK] = nCrank_raw;
  assign raw[CH_MODE]  = nMode_raw;
  assign raw[CH_TRIP]  = nTrip_raw;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam int unsigned DB_I = (i == CH_FORK || i == CH_CRANK) ? SENSOR_DB : BUTTON_DB;
    debounce_chan #(.DB(DB_I), .CNT_W(CNT_W)) u_chan (
      .clk_i  (Clock),
      .rst_i  (Reset),
      .raw_i  (raw[i]),
      .clean_o(clean[i]),
      .pulse_o(pulse[i])
    );
  end

  logic [CNT_W-1:0] hold_q, hold_d;

  always_ff @(posedge Clock) begin
    if (Reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end

  always_comb begin
    hold_d = hold_q;
    if (clean[CH_MODE])         hold_d = '0;
    else if (hold_q != HOLD_MAX) hold_d = hold_q + CNT_W'(1);
  end

  // Gate with the live level so ModeHold drops the same cycle nMode rises.
  assign ModeHold = !clean[CH_MODE] && (hold_q == HOLD_MAX);

  assign nFork      = clean[CH_FORK];
  assign nCrank     = clean[CH_CRANK];
  assign nMode      = clean[CH_MODE];
  assign nTrip      = clean[CH_TRIP];
  assign ForkPulse  = pulse[CH_FORK];
  assign CrankPulse = pulse[CH_CRANK];
  assign ModePress  = pulse[CH_MODE];
  assign TripPress  = pulse[CH_TRIP];

endmodule
